// File: rtl/bbq_op_sched_pkg.sv
// Control-side types for the BBQ operation scheduler.
package BBQctrl;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ENQ  = 2'd1,
        GRANT_DEQ  = 2'd2
    } grant_t;

endpackage

// File: rtl/heap_ops_pkg.sv
// Command encoding shared by every block that talks to the BBQ heap.
package heap_ops;

    typedef enum logic [1:0] {
        HEAP_OP_ENQUE     = 2'd0,
        HEAP_OP_DEQUE_MIN = 2'd1,
        HEAP_OP_DEQUE_MAX = 2'd2
    } heap_op_t;

endpackage

// File: rtl/bbq_op_sched_out_fifo.sv
// Output buffer for dequeued buffer addresses; head is visible combinationally.
module bbq_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full buffer is legal only when a pop frees the slot in the same cycle.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/bbq_op_sched.sv
// Issues enqueue/dequeue commands to the BBQ heap, arbitrating round-robin and
// throttling dequeues by the free space left in the output buffer.
module bbq_op_sched
    import heap_ops::*;
    import BBQctrl::*;
#(
    parameter int HEAP_ENTRY_DWIDTH    = 32,
    parameter int HEAP_PRIORITY_AWIDTH = 7,
    parameter int HEAP_MAX_NUM_ENTRIES = 131071,
    parameter int OUT_BUFF_SIZE        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [HEAP_PRIORITY_AWIDTH-1:0] in_priority,
    input  logic [HEAP_ENTRY_DWIDTH-1:0]    in_buff_addr,
    input  logic                            heap_ready,
    output logic                            heap_in_valid,
    output heap_op_t                        heap_in_op,
    output logic [HEAP_PRIORITY_AWIDTH-1:0] heap_in_priority,
    output logic [HEAP_ENTRY_DWIDTH-1:0]    heap_in_data,
    input  logic                            heap_out_valid,
    input  logic [HEAP_ENTRY_DWIDTH-1:0]    heap_out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [HEAP_ENTRY_DWIDTH-1:0]    out_buff_addr,
    output logic                            err_overflow
);

    localparam int ENT_W = $clog2(HEAP_MAX_NUM_ENTRIES + 1);
    localparam int FCW   = $clog2(OUT_BUFF_SIZE + 1);
    localparam int SUM_W = FCW + 1;
    localparam logic [ENT_W-1:0] MAX_ENT    = ENT_W'(HEAP_MAX_NUM_ENTRIES);
    localparam logic [FCW-1:0]   FIFO_FULL  = FCW'(OUT_BUFF_SIZE);
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'(OUT_BUFF_SIZE);

    sched_state_t     state;
    sched_state_t     state_nxt;
    grant_t           grant;
    grant_t           last_grant;
    logic [ENT_W-1:0] entry_cnt;
    logic [FCW-1:0]   inflight;
    logic [FCW-1:0]   fifo_cnt;
    logic             has_credit;
    logic             enq_ok;
    logic             deq_ok;
    logic             fifo_pop;
    logic             ret_err;
    logic             ret_push;
    logic             ret_taken;

    // Every outstanding dequeue owns a reserved buffer slot, so results can never overflow.
    assign has_credit = (SUM_W'(fifo_cnt) + SUM_W'(inflight)) < CREDIT_MAX;
    assign enq_ok = (state == ST_RUN) && heap_ready && in_valid && (entry_cnt < MAX_ENT);
    assign deq_ok = (state == ST_RUN) && heap_ready && (entry_cnt != '0) && has_credit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            entry_cnt    <= '0;
            inflight     <= '0;
            last_grant   <= GRANT_DEQ;
            err_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (enq_ok && deq_ok) last_grant <= grant;
            case (grant)
                GRANT_ENQ: entry_cnt <= entry_cnt + 1'b1;
                GRANT_DEQ: entry_cnt <= entry_cnt - 1'b1;
                default:   ;
            endcase
            inflight <= inflight + FCW'(grant == GRANT_DEQ) - FCW'(ret_taken);
            if (ret_err) err_overflow <= 1'b1;
        end
    end

    always_comb begin
        state_nxt        = state;
        grant            = GRANT_NONE;
        in_ready         = 1'b0;
        heap_in_valid    = 1'b0;
        heap_in_op       = HEAP_OP_ENQUE;
        heap_in_priority = '0;
        heap_in_data     = '0;
        case (state)
            ST_INIT: if (heap_ready) state_nxt = ST_RUN;
            ST_RUN: begin
                if (enq_ok && deq_ok)
                    grant = (last_grant == GRANT_DEQ) ? GRANT_ENQ : GRANT_DEQ;
                else if (enq_ok)
                    grant = GRANT_ENQ;
                else if (deq_ok)
                    grant = GRANT_DEQ;
            end
            default: state_nxt = ST_INIT;
        endcase
        if (rst) grant = GRANT_NONE;
        case (grant)
            GRANT_ENQ: begin
                in_ready         = 1'b1;
                heap_in_valid    = 1'b1;
                heap_in_op       = HEAP_OP_ENQUE;
                heap_in_priority = in_priority;
                heap_in_data     = in_buff_addr;
            end
            GRANT_DEQ: begin
                heap_in_valid = 1'b1;
                heap_in_op    = HEAP_OP_DEQUE_MIN;
            end
            default: ;
        endcase
    end

    // Unsolicited results, or results with nowhere to go, are dropped and flagged.
    assign out_valid = !rst && (fifo_cnt != '0);
    assign fifo_pop  = out_valid && out_ready;
    assign ret_err   = heap_out_valid &&
                       ((inflight == '0) || ((fifo_cnt == FIFO_FULL) && !fifo_pop));
    assign ret_push  = heap_out_valid && !ret_err;
    assign ret_taken = heap_out_valid && (inflight != '0);

    bbq_out_fifo #(
        .WIDTH (HEAP_ENTRY_DWIDTH),
        .DEPTH (OUT_BUFF_SIZE)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ret_push),
        .push_data (heap_out_data),
        .pop       (fifo_pop),
        .head_data (out_buff_addr),
        .count     (fifo_cnt)
    );

endmodule

// File: tb/tb_bbq_op_sched.sv
// Bench for bbq_op_sched: a queue-based scheduler/heap model checked cycle by cycle.
`timescale 1ns/1ps
module tb_bbq_op_sched;
    import heap_ops::*;

    localparam int DW   = 32;
    localparam int PW   = 7;
    localparam int MAXN = 131071;
    localparam int OBS  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_ready, heap_ready, heap_in_valid;
    logic          heap_out_valid, out_valid, out_ready, err_overflow;
    logic [PW-1:0] in_priority, heap_in_priority;
    logic [DW-1:0] in_buff_addr, heap_in_data, heap_out_data, out_buff_addr;
    heap_op_t      heap_in_op;

    logic          s_rst, s_in_valid, s_in_ready, s_heap_ready, s_heap_in_valid;
    logic          s_heap_out_valid, s_out_valid, s_out_ready, s_err_overflow;
    logic [PW-1:0] s_in_priority, s_heap_in_priority;
    logic [DW-1:0] s_in_buff_addr, s_heap_in_data, s_heap_out_data, s_out_buff_addr;
    heap_op_t      s_heap_in_op;

    bbq_op_sched u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_priority(in_priority), .in_buff_addr(in_buff_addr),
        .heap_ready(heap_ready), .heap_in_valid(heap_in_valid), .heap_in_op(heap_in_op),
        .heap_in_priority(heap_in_priority), .heap_in_data(heap_in_data),
        .heap_out_valid(heap_out_valid), .heap_out_data(heap_out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_buff_addr(out_buff_addr),
        .err_overflow(err_overflow)
    );

    bbq_op_sched #(.HEAP_MAX_NUM_ENTRIES(3), .OUT_BUFF_SIZE(2)) u_small (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_priority(s_in_priority), .in_buff_addr(s_in_buff_addr),
        .heap_ready(s_heap_ready), .heap_in_valid(s_heap_in_valid), .heap_in_op(s_heap_in_op),
        .heap_in_priority(s_heap_in_priority), .heap_in_data(s_heap_in_data),
        .heap_out_valid(s_heap_out_valid), .heap_out_data(s_heap_out_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_buff_addr(s_out_buff_addr),
        .err_overflow(s_err_overflow)
    );

    typedef struct { logic [PW-1:0] prio; logic [DW-1:0] addr; } ent_t;
    typedef struct { int due; logic [DW-1:0] data; } ret_t;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_enq = 0, n_deq = 0, fix_lat = 0;
    bit inj_err = 0;

    // Reference model state
    bit            m_run, m_last_enq, m_err;
    int            m_cnt, m_infl;
    logic [DW-1:0] m_fifo[$];
    ent_t          heap_q[$];
    ret_t          ret_q[$];

    // Expected small-instance handshake per cycle after reset (MAX=3, buffer=2, no returns)
    int exp_ir[11] = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0};
    int exp_hv[11] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    task automatic drive_ret();
        heap_out_valid = 1'b0;
        heap_out_data  = '0;
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            heap_out_valid = 1'b1;
            heap_out_data  = ret_q[0].data;
        end
    endtask

    task automatic rand_payload();
        in_priority  = PW'($urandom_range(0, 127));
        in_buff_addr = $urandom;
    endtask

    task automatic cycle();
        bit e, d, cont, pop, push;
        int idx;
        ent_t ent;
        ret_t r;
        logic [DW-1:0] pdata, tmp;
        @(negedge clk);
        e = m_run && heap_ready && in_valid && (m_cnt < MAXN);
        d = m_run && heap_ready && (m_cnt > 0) && ((m_fifo.size() + m_infl) < OBS);
        cont = e && d;
        if (cont) begin
            if (m_last_enq) e = 0;
            else d = 0;
        end
        check_eq("in_ready", in_ready, e);
        check_eq("heap_in_valid", heap_in_valid, e || d);
        if (e) begin
            check_eq("enq_op", heap_in_op, HEAP_OP_ENQUE);
            check_eq("enq_prio", heap_in_priority, in_priority);
            check_eq("enq_data", heap_in_data, in_buff_addr);
        end
        if (d) begin
            check_eq("deq_op", heap_in_op, HEAP_OP_DEQUE_MIN);
            check_eq("deq_prio", heap_in_priority, 0);
            check_eq("deq_data", heap_in_data, 0);
        end
        if (heap_in_valid === 1'b1 && heap_in_op == HEAP_OP_DEQUE_MIN) n_deq++;
        check_eq("out_valid", out_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) check_eq("out_buff_addr", out_buff_addr, m_fifo[0]);
        check_eq("err_overflow", err_overflow, m_err);
        @(posedge clk);
        pop = (m_fifo.size() > 0) && out_ready;
        push = 0;
        pdata = heap_out_data;
        if (heap_out_valid) begin
            if (m_infl == 0 || (m_fifo.size() == OBS && !pop)) begin
                m_err = 1;
                if (m_infl > 0) m_infl--;
            end else begin
                push = 1;
                m_infl--;
            end
            if (!inj_err && ret_q.size() > 0) r = ret_q.pop_front();
        end
        if (pop) tmp = m_fifo.pop_front();
        if (push) m_fifo.push_back(pdata);
        if (!m_run && heap_ready) m_run = 1;
        if (cont) m_last_enq = e;
        if (e) begin
            m_cnt++;
            n_enq++;
            ent.prio = in_priority;
            ent.addr = in_buff_addr;
            heap_q.push_back(ent);
        end
        if (d) begin
            m_cnt--;
            m_infl++;
            idx = 0;
            foreach (heap_q[i]) if (heap_q[i].prio < heap_q[idx].prio) idx = i;
            r.data = heap_q[idx].addr;
            heap_q.delete(idx);
            r.due = cyc + ((fix_lat != 0) ? fix_lat : int'($urandom_range(1, 5)));
            ret_q.push_back(r);
        end
        cyc++;
        #1;
        drive_ret();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        heap_out_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_in_ready", in_ready, 0);
            check_eq("rst_heap_in_valid", heap_in_valid, 0);
            check_eq("rst_out_valid", out_valid, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        m_run = 0; m_last_enq = 0; m_err = 0; m_cnt = 0; m_infl = 0;
        m_fifo.delete(); heap_q.delete(); ret_q.delete();
        n_deq = 0; n_enq = 0;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_priority = '0; in_buff_addr = '0;
        heap_ready = 0; heap_out_valid = 0; heap_out_data = '0; out_ready = 0;
        s_rst = 1; s_in_valid = 1; s_in_priority = 7'd2; s_in_buff_addr = 32'h0000_0A00;
        s_heap_ready = 1; s_heap_out_valid = 0; s_heap_out_data = '0; s_out_ready = 0;

        // Full heap on the small instance: dequeues starve on credits, enqueues stop at 3 entries
        repeat (2) begin
            @(negedge clk);
            check_eq("s_rst_in_ready", s_in_ready, 0);
            @(posedge clk);
            #1;
        end
        s_rst = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check_eq("s_in_ready", s_in_ready, exp_ir[i]);
            check_eq("s_heap_in_valid", s_heap_in_valid, exp_hv[i]);
            if (exp_hv[i] == 1 && exp_ir[i] == 0) check_eq("s_deq_op", s_heap_in_op, HEAP_OP_DEQUE_MIN);
            check_eq("s_err", s_err_overflow, 0);
            @(posedge clk);
            #1;
        end

        // Initialisation: heap not ready for 5 cycles while a request waits
        do_reset();
        in_valid = 1; in_priority = 7'd5; in_buff_addr = 32'h55;
        repeat (5) cycle();
        heap_ready = 1;
        cycle();
        cycle();
        in_valid = 0; out_ready = 1;
        repeat (15) cycle();

        // Single enqueue/dequeue with a fixed 4-cycle heap latency
        fix_lat = 4;
        in_valid = 1; in_priority = 7'd3; in_buff_addr = 32'h100;
        cycle();
        in_valid = 0;
        repeat (10) cycle();
        fix_lat = 0;

        // Contention: continuous requests alternate with dequeues
        in_valid = 1;
        repeat (12) begin rand_payload(); cycle(); end
        in_valid = 0;
        repeat (40) cycle();

        // Back-pressure: 20 entries, output stalled
        do_reset();
        heap_ready = 1; out_ready = 0; in_valid = 1;
        for (int g = 0; g < 200 && n_enq < 20; g++) begin rand_payload(); cycle(); end
        in_valid = 0;
        check_eq("bp_enq20", n_enq, 20);
        repeat (60) cycle();
        check_eq("bp_deq16", n_deq, 16);
        out_ready = 1;
        cycle();
        out_ready = 0;
        repeat (20) cycle();
        check_eq("bp_deq17", n_deq, 17);

        // Unsolicited heap result with nothing in flight
        heap_out_valid = 1; heap_out_data = 32'hDEAD_BEEF; inj_err = 1;
        cycle();
        inj_err = 0;
        repeat (4) cycle();
        check_eq("err_sticky", err_overflow, 1);
        out_ready = 1;
        repeat (40) cycle();

        // Randomised traffic with a mid-run reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            in_valid   = ($urandom_range(0, 9) < 7);
            heap_ready = ($urandom_range(0, 19) < 17);
            out_ready  = ($urandom_range(0, 1) == 1);
            rand_payload();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
